// File: rtl/sssp_phase_ctrl.sv
// Level-synchronous sequencer for the SSSP edge-centric pipelines: per level and partition it
// loads vertex lines, streams edge lines, drains, and repeats levels while updates are reported.
module sssp_phase_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int VERTEX_LINES = 32,
  parameter int DRAIN        = 2,
  parameter int NPIPE        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [15:0]      num_partitions_i,
  input  logic [15:0]      max_level_i,
  output logic             part_req_o,
  output logic [15:0]      part_idx_o,
  output logic             part_phase_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [511:0]     in_data_i,
  input  logic             in_last_i,
  output logic [511:0]     word_in_o,
  output logic             word_in_valid_o,
  output logic [31:0]      w_addr_o,
  output logic [1:0]       control_o,
  output logic             last_input_in_o,
  output logic [15:0]      current_level_o,
  input  logic [NPIPE-1:0] pipe_valid_out_i,
  input  logic             pipe_last_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      levels_run_o
);

  localparam int IDX_W = $clog2(VERTEX_LINES + 1);
  localparam int CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VERTEX_LINES - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((DRAIN > 0) ? (DRAIN - 1) : 0);
  localparam bit DRAIN_NONE = (DRAIN == 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_V     = 3'd1,
    S_LOAD_V    = 3'd2,
    S_REQ_E     = 3'd3,
    S_STREAM_E  = 3'd4,
    S_DRAIN     = 3'd5,
    S_LEVEL_END = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      num_part_q, num_part_d;
  logic [15:0]      max_level_q, max_level_d;
  logic [15:0]      part_idx_q, part_idx_d;
  logic [15:0]      level_q, level_d;
  logic             upd_q, upd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             part_phase_q, part_phase_d;
  logic [15:0]      levels_run_q, levels_run_d;
  logic             part_req_q, part_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       control_q, control_d;
  logic [511:0]     word_in_q, word_in_d;
  logic             wiv_q, wiv_d;
  logic [31:0]      w_addr_q, w_addr_d;
  logic             last_q, last_d;

  logic        in_ready_s;
  logic        hs_s;
  logic        active_s;
  logic        upd_now_s;
  logic        finish_s;
  logic [31:0] base_s;

  assign in_ready_s = (state_q == S_LOAD_V) || (state_q == S_STREAM_E);
  assign hs_s       = in_ready_s && in_valid_i;
  assign active_s   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign upd_now_s  = upd_q || (active_s && (|pipe_valid_out_i));
  assign base_s     = 32'(part_idx_q) << ADDR_W;

  // Sequencer next state: partition/level bookkeeping and the drain countdown.
  always_comb begin
    state_d      = state_q;
    num_part_d   = num_part_q;
    max_level_d  = max_level_q;
    part_idx_d   = part_idx_q;
    level_d      = level_q;
    upd_d        = upd_now_s;
    idx_d        = idx_q;
    seen_d       = seen_q;
    dcnt_d       = dcnt_q;
    levels_run_d = levels_run_q;
    finish_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_part_d  = num_partitions_i;
          max_level_d = max_level_i;
          if (num_partitions_i == 16'd0) begin
            levels_run_d = 16'd0;
            state_d      = S_DONE;
          end else begin
            level_d    = 16'd0;
            part_idx_d = 16'd0;
            upd_d      = 1'b0;
            state_d    = S_REQ_V;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ_V: begin
        idx_d   = '0;
        state_d = S_LOAD_V;
      end
      S_LOAD_V: begin
        if (hs_s) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_REQ_E;
          end else begin
            state_d = S_LOAD_V;
          end
        end else begin
          state_d = S_LOAD_V;
        end
      end
      S_REQ_E: begin
        state_d = S_STREAM_E;
      end
      S_STREAM_E: begin
        if (hs_s && in_last_i) begin
          seen_d  = 1'b0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM_E;
        end
      end
      S_DRAIN: begin
        // A second pipe_last_out during the countdown is deliberately ignored.
        if (!seen_q) begin
          if (pipe_last_out_i) begin
            if (DRAIN_NONE) begin
              finish_s = 1'b1;
            end else begin
              seen_d = 1'b1;
              dcnt_d = CNT_INIT;
            end
          end else begin
            seen_d = 1'b0;
          end
        end else if (dcnt_q == '0) begin
          finish_s = 1'b1;
        end else begin
          dcnt_d = dcnt_q - CNT_W'(1);
        end
        if (finish_s) begin
          seen_d = 1'b0;
          if (({1'b0, part_idx_q} + 17'd1) < {1'b0, num_part_q}) begin
            part_idx_d = part_idx_q + 16'd1;
            state_d    = S_REQ_V;
          end else begin
            state_d = S_LEVEL_END;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_LEVEL_END: begin
        if (upd_now_s && (level_q < max_level_q)) begin
          level_d    = level_q + 16'd1;
          part_idx_d = 16'd0;
          upd_d      = 1'b0;
          state_d    = S_REQ_V;
        end else begin
          levels_run_d = level_q + 16'd1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output register next values; control follows the line cycle so it never changes under a line.
  always_comb begin
    part_req_d   = (state_d == S_REQ_V) || (state_d == S_REQ_E);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    part_phase_d = part_phase_q;
    if (state_d == S_REQ_V) begin
      part_phase_d = 1'b0;
    end else if (state_d == S_REQ_E) begin
      part_phase_d = 1'b1;
    end else begin
      part_phase_d = part_phase_q;
    end
    case (state_q)
      S_LOAD_V:                     control_d = 2'd1;
      S_REQ_E, S_STREAM_E, S_DRAIN: control_d = 2'd2;
      default:                      control_d = 2'd0;
    endcase
    wiv_d  = hs_s;
    last_d = hs_s && (state_q == S_STREAM_E) && in_last_i;
    if (hs_s) begin
      word_in_d = in_data_i;
      if (state_q == S_LOAD_V) begin
        w_addr_d = base_s + 32'(idx_q);
      end else begin
        w_addr_d = base_s;
      end
    end else begin
      word_in_d = word_in_q;
      w_addr_d  = w_addr_q;
    end
  end

  // Control-path registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_part_q   <= 16'd0;
      max_level_q  <= 16'd0;
      part_idx_q   <= 16'd0;
      level_q      <= 16'd0;
      upd_q        <= 1'b0;
      idx_q        <= '0;
      seen_q       <= 1'b0;
      dcnt_q       <= '0;
      part_phase_q <= 1'b0;
      levels_run_q <= 16'd0;
      part_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      control_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      num_part_q   <= num_part_d;
      max_level_q  <= max_level_d;
      part_idx_q   <= part_idx_d;
      level_q      <= level_d;
      upd_q        <= upd_d;
      idx_q        <= idx_d;
      seen_q       <= seen_d;
      dcnt_q       <= dcnt_d;
      part_phase_q <= part_phase_d;
      levels_run_q <= levels_run_d;
      part_req_q   <= part_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      control_q    <= control_d;
    end
  end

  // Line-forwarding registers broadcast to the pipelines.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_in_q <= 512'd0;
      wiv_q     <= 1'b0;
      w_addr_q  <= 32'd0;
      last_q    <= 1'b0;
    end else begin
      word_in_q <= word_in_d;
      wiv_q     <= wiv_d;
      w_addr_q  <= w_addr_d;
      last_q    <= last_d;
    end
  end

  assign in_ready_o      = in_ready_s;
  assign part_req_o      = part_req_q;
  assign part_idx_o      = part_idx_q;
  assign part_phase_o    = part_phase_q;
  assign word_in_o       = word_in_q;
  assign word_in_valid_o = wiv_q;
  assign w_addr_o        = w_addr_q;
  assign control_o       = control_q;
  assign last_input_in_o = last_q;
  assign current_level_o = level_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign levels_run_o    = levels_run_q;

endmodule

// File: tb/tb_sssp_phase_ctrl.sv
// Directed bench for sssp_phase_ctrl: an upstream/pipeline emulator plus a transaction-level
// model (expected requests, lines and done values) checked every cycle.
module tb_sssp_phase_ctrl;

  localparam int AW = 8;
  localparam int VL = 2;
  localparam int DR = 2;
  localparam int NP = 4;

  typedef struct packed {
    logic [511:0] data;
    logic [31:0]  addr;
    logic [1:0]   ctl;
    logic         last;
    logic [15:0]  lvl;
  } line_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   num_partitions = 16'd0;
  logic [15:0]   max_level = 16'd0;
  logic          part_req_o, part_phase_o, in_ready_o;
  logic [15:0]   part_idx_o, current_level_o, levels_run_o;
  logic          in_valid, in_last;
  logic [511:0]  in_data;
  logic [511:0]  word_in_o;
  logic          word_in_valid_o, last_input_in_o, busy_o, done_o;
  logic [31:0]   w_addr_o;
  logic [1:0]    control_o;
  logic [NP-1:0] pipe_valid_out;
  logic          pipe_last_out;

  int errors = 0;
  int checks = 0;

  int          cfg_np = 1, cfg_ml = 0, cfg_ne = 1;
  logic [15:0] cfg_inj = 16'd0;
  bit          cfg_bub = 1'b0, cfg_dbl = 1'b0;
  int          req_cnt = 0;

  line_t       exp_lines[$];
  logic [16:0] exp_reqs[$];
  logic [15:0] exp_done[$];

  int hs_tot = 0, wiv_tot = 0, req_tot = 0, done_tot = 0, a101_tot = 0;
  logic [15:0] lr_last = 16'd0;
  logic [15:0] lvl_last = 16'd0;

  sssp_phase_ctrl #(.ADDR_W(AW), .VERTEX_LINES(VL), .DRAIN(DR), .NPIPE(NP)) dut (
    .clk(clk), .rst(rst), .start_i(start),
    .num_partitions_i(num_partitions), .max_level_i(max_level),
    .part_req_o(part_req_o), .part_idx_o(part_idx_o), .part_phase_o(part_phase_o),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_data_i(in_data), .in_last_i(in_last),
    .word_in_o(word_in_o), .word_in_valid_o(word_in_valid_o), .w_addr_o(w_addr_o),
    .control_o(control_o), .last_input_in_o(last_input_in_o), .current_level_o(current_level_o),
    .pipe_valid_out_i(pipe_valid_out), .pipe_last_out_i(pipe_last_out),
    .busy_o(busy_o), .done_o(done_o), .levels_run_o(levels_run_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] line_data(input int lvl, input int p, input int ph, input int k);
    logic [31:0] tag;
    tag = {8'(lvl), 8'(p), (ph != 0) ? 8'hE0 : 8'h70, 8'(k)};
    return {16{tag}};
  endfunction

  // Transaction-level expectation of a whole run from the configuration.
  task automatic build_model();
    int lvl;
    bit more;
    line_t e;
    exp_lines.delete();
    exp_reqs.delete();
    exp_done.delete();
    if (cfg_np == 0) begin
      exp_done.push_back(16'd0);
      return;
    end
    lvl  = 0;
    more = 1'b1;
    while (more) begin
      for (int p = 0; p < cfg_np; p++) begin
        exp_reqs.push_back({1'b0, 16'(p)});
        for (int k = 0; k < VL; k++) begin
          e = '{line_data(lvl, p, 0, k), 32'((p << AW) + k), 2'd1, 1'b0, 16'(lvl)};
          exp_lines.push_back(e);
        end
        exp_reqs.push_back({1'b1, 16'(p)});
        for (int k = 0; k < cfg_ne; k++) begin
          e = '{line_data(lvl, p, 1, k), 32'(p << AW), 2'd2, (k == cfg_ne - 1), 16'(lvl)};
          exp_lines.push_back(e);
        end
      end
      if (cfg_inj[lvl] && (lvl < cfg_ml)) lvl++;
      else more = 1'b0;
    end
    exp_done.push_back(16'(lvl + 1));
  endtask

  // Upstream line source and pipeline update injector.
  initial begin : upstream
    bit clr, hs, nreq, tog;
    int left, k, d_lvl, d_p, d_ph;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; pipe_valid_out = '0;
    left = 0; k = 0; tog = 1'b0; d_lvl = 0; d_p = 0; d_ph = 0;
    forever begin
      @(negedge clk);
      clr = rst; hs = in_valid && in_ready_o; nreq = part_req_o;
      @(posedge clk); #1;
      pipe_valid_out = '0;
      if (clr) begin
        left = 0;
      end else begin
        if (hs) begin left--; k++; hs_tot++; end
        if (nreq) begin
          d_lvl = req_cnt / (2 * cfg_np);
          d_p   = (req_cnt / 2) % cfg_np;
          d_ph  = req_cnt % 2;
          req_cnt++;
          k = 0;
          left = (d_ph != 0) ? cfg_ne : VL;
          if ((d_ph != 0) && cfg_inj[d_lvl]) pipe_valid_out = 4'b0010;
        end
      end
      tog = !tog;
      if ((left > 0) && (!cfg_bub || tog)) begin
        in_valid = 1'b1;
        in_data  = line_data(d_lvl, d_p, d_ph, k);
        in_last  = (d_ph != 0) && (left == 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
  end

  // Pipeline-0 last-line echo, optionally with a second stray pulse.
  initial begin : pipe_echo
    bit seen, clr;
    int pcnt;
    pcnt = 0; pipe_last_out = 1'b0;
    forever begin
      @(negedge clk);
      seen = !rst && word_in_valid_o && last_input_in_o;
      clr  = rst;
      @(posedge clk); #1;
      if (clr) pcnt = 0;
      else if (seen) pcnt = 4;
      else if (pcnt > 0) pcnt--;
      pipe_last_out = (pcnt == 2) || (cfg_dbl && (pcnt == 1));
    end
  end

  // Per-cycle comparison against the model queues.
  initial begin : compare
    line_t e;
    logic [16:0] r;
    logic [15:0] d;
    bit dtrk;
    int dk;
    dtrk = 1'b0; dk = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dtrk = 1'b0;
      end else begin
        if (word_in_valid_o) begin
          wiv_tot++;
          if ((w_addr_o == 32'h101) && (control_o == 2'd1)) a101_tot++;
          if (exp_lines.size() == 0) begin
            chk("unexpected_line", 1'b1, 1'b0);
          end else begin
            e = exp_lines.pop_front();
            chk("line_data", word_in_o, e.data);
            chk("line_addr", w_addr_o, e.addr);
            chk("line_ctl", control_o, e.ctl);
            chk("line_last", last_input_in_o, e.last);
            chk("line_level", current_level_o, e.lvl);
            chk("line_busy", busy_o, 1'b1);
            lvl_last = current_level_o;
          end
        end else begin
          chk("last_without_line", last_input_in_o, 1'b0);
        end
        if (part_req_o) begin
          req_tot++;
          if (exp_reqs.size() == 0) begin
            chk("unexpected_req", 1'b1, 1'b0);
          end else begin
            r = exp_reqs.pop_front();
            chk("req_idx", part_idx_o, r[15:0]);
            chk("req_phase", part_phase_o, r[16]);
          end
        end
        if (done_o) begin
          done_tot++;
          lr_last = levels_run_o;
          if (exp_done.size() == 0) begin
            chk("unexpected_done", 1'b1, 1'b0);
          end else begin
            d = exp_done.pop_front();
            chk("levels_run", levels_run_o, d);
          end
        end
        if (dtrk) begin
          dk++;
          if (dk <= DR + 1) begin
            chk("drain_ctl_hold", control_o, 2'd2);
          end else begin
            chk("drain_ctl_release", control_o, 2'd0);
            dtrk = 1'b0;
          end
        end else if (pipe_last_out) begin
          dtrk = 1'b1;
          dk   = 0;
          chk("drain_ctl_at_last", control_o, 2'd2);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_word_in"}, word_in_o, 512'd0);
    chk({tag, "_wiv"}, word_in_valid_o, 1'b0);
    chk({tag, "_w_addr"}, w_addr_o, 32'd0);
    chk({tag, "_control"}, control_o, 2'd0);
    chk({tag, "_last_in"}, last_input_in_o, 1'b0);
    chk({tag, "_level"}, current_level_o, 16'd0);
    chk({tag, "_part_req"}, part_req_o, 1'b0);
    chk({tag, "_part_idx"}, part_idx_o, 16'd0);
    chk({tag, "_part_phase"}, part_phase_o, 1'b0);
    chk({tag, "_in_ready"}, in_ready_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_levels_run"}, levels_run_o, 16'd0);
  endtask

  task automatic launch(input int np, input int ml, input int ne, input logic [15:0] inj,
                        input bit bub, input bit dbl);
    cfg_np = np; cfg_ml = ml; cfg_ne = ne; cfg_inj = inj; cfg_bub = bub; cfg_dbl = dbl;
    build_model();
    req_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; num_partitions = 16'(np); max_level = 16'(ml);
    @(posedge clk); #1;
    start = 1'b0; num_partitions = 16'd9; max_level = 16'd0;
  endtask

  task automatic run_case(input int np, input int ml, input int ne, input logic [15:0] inj,
                          input bit bub, input bit dbl, input bit restart);
    int d0, w0, h0;
    d0 = done_tot; w0 = wiv_tot; h0 = hs_tot;
    launch(np, ml, ne, inj, bub, dbl);
    @(negedge clk);
    if (np != 0) chk("busy_after_start", busy_o, 1'b1);
    for (int i = 0; i < 3000 && done_tot == d0; i++) begin
      @(posedge clk); #1;
      start = restart && (i == 10);
    end
    start = 1'b0;
    chk("done_count", done_tot - d0, 1);
    chk("lines_left", exp_lines.size(), 0);
    chk("reqs_left", exp_reqs.size(), 0);
    chk("wiv_eq_hs", wiv_tot - w0, hs_tot - h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", busy_o, 1'b0);
  endtask

  initial begin : main
    int r0, w0, a0, d0;
    bit reached;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single partition, 2 vertex lines, 3 edge lines, no updates.
    r0 = req_tot; w0 = wiv_tot;
    run_case(1, 5, 3, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("t1_levels", lr_last, 16'd1);
    chk("t1_reqs", req_tot - r0, 2);
    chk("t1_lines", wiv_tot - w0, 5);

    // Three partitions; a start pulse during the run must be ignored.
    r0 = req_tot; a0 = a101_tot;
    run_case(3, 0, 2, 16'd0, 1'b0, 1'b0, 1'b1);
    chk("t2_reqs", req_tot - r0, 6);
    chk("t2_addr_101", a101_tot - a0, 1);
    chk("t2_levels", lr_last, 16'd1);

    // Update in level 0 only.
    r0 = req_tot;
    run_case(2, 5, 2, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("t3_levels", lr_last, 16'd2);
    chk("t3_last_level", lvl_last, 16'd1);
    chk("t3_reqs", req_tot - r0, 8);

    // Updates every level, capped by max_level.
    run_case(1, 2, 2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("t4_levels", lr_last, 16'd3);

    // Bubbled input, single-line edge phases, stray second pipe_last_out.
    w0 = wiv_tot;
    run_case(2, 3, 1, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("t5_lines", wiv_tot - w0, 6);

    // Reset in the middle of edge streaming.
    d0 = done_tot;
    launch(1, 3, 8, 16'd0, 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      reached = word_in_valid_o && (control_o == 2'd2);
    end
    chk("reach_stream", reached, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    exp_lines.delete(); exp_reqs.delete(); exp_done.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    chk("no_done_after_rst", done_tot - d0, 0);

    run_case(1, 0, 2, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("t7_levels", lr_last, 16'd1);

    // Empty run.
    run_case(0, 4, 1, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("t8_levels", lr_last, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sssp_phase_ctrl.md
# sssp_phase_ctrl

Sequencer for the SSSP edge-centric pipelines. It runs level-synchronous iterations. For each level and each vertex partition it first loads the partition's vertex lines into every `sssp_pipeline` vertex RAM, then streams that partition's edge lines through the pipelines. It drives the broadcast `control`, `w_addr`, `word_in`, `word_in_valid`, `last_input_in` and `current_level` signals, and decides from pipeline output activity whether another level is needed.

## Interface
- `ADDR_W`, 8: vertex RAM address width; must match the pipelines.
- `VERTEX_LINES`, 32: vertex cache lines loaded per partition; must be 1..2^ADDR_W.
- `DRAIN`, 2: extra cycles held in `control=2` after `pipe_last_out`.
- `NPIPE`, 4: number of pipelines observed.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: pulse; begins a run; ignored while `busy`.
- `num_partitions` in 16: partitions per level; sampled on `start`.
- `max_level` in 16: last level allowed; sampled on `start`.
- `part_req` out 1: one-cycle pulse asking upstream to stream one phase of partition `part_idx`.
- `part_idx` out 16: partition index, held stable from `part_req` to the end of that phase.
- `part_phase` out 1: 0 = vertex lines, 1 = edge lines.
- `in_valid` in 1: upstream line-stream handshake.
- `in_ready` out 1: upstream line-stream handshake.
- `in_data` in 512: upstream line data.
- `in_last` in 1: upstream last edge line; meaningful in the edge phase only.
- `word_in` out 512: broadcast to pipelines.
- `word_in_valid` out 1: broadcast to pipelines.
- `w_addr` out 32: broadcast to pipelines.
- `control` out 2: broadcast to pipelines.
- `last_input_in` out 1: broadcast to pipelines.
- `current_level` out 16: broadcast to pipelines.
- `pipe_valid_out` in NPIPE: `valid_out` of each pipeline.
- `pipe_last_out` in 1: `last_input_out` of pipeline 0.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done` out 1: one-cycle pulse at end of run.
- `levels_run` out 16: number of levels executed; valid with `done`.

## Operation
- States: IDLE, REQ_V, LOAD_V, REQ_E, STREAM_E, DRAIN, LEVEL_END, DONE.
- IDLE, on `start`:
  - `num_partitions==0` goes to DONE with `levels_run=0`.
  - Otherwise clear `current_level`, `part_idx` and the `upd` flag, then go to REQ_V.
- REQ_V: pulse `part_req` with `part_phase=0`, go to LOAD_V.
- LOAD_V:
  - `in_ready=1`.
  - On each handshake, register `in_data` into `word_in`, assert `word_in_valid`, and set `w_addr = (part_idx << ADDR_W) + idx`.
  - `idx` counts 0..VERTEX_LINES-1.
  - After handshake VERTEX_LINES-1, drop `in_ready` and go to REQ_E.
- REQ_E: pulse `part_req` with `part_phase=1`, go to STREAM_E.
- STREAM_E:
  - `in_ready=1`.
  - Lines are forwarded the same way, with `w_addr` held at the partition base.
  - On the handshake with `in_last=1`, assert `last_input_in` in the same output cycle as that line, then go to DRAIN.
- DRAIN:
  - Hold `control=2`.
  - After `pipe_last_out` is seen, wait `DRAIN` more cycles.
  - Then, if `part_idx < num_partitions-1`, increment `part_idx` and go to REQ_V; otherwise go to LEVEL_END.
- `upd` flag: set whenever any `pipe_valid_out` bit is high in any state between REQ_V and LEVEL_END.
- LEVEL_END:
  - If `upd` and `current_level < max_level`: increment `current_level`, clear `part_idx` and `upd`, go to REQ_V.
  - Otherwise go to DONE.
- DONE: pulse `done` with `levels_run = current_level+1` (0 for the empty case), return to IDLE.
- `control` encoding:
  - 1 in LOAD_V.
  - 2 in REQ_E, STREAM_E and DRAIN.
  - 0 elsewhere.
  - `control` must never change while a line is in flight in a pipeline.
- Arithmetic:
  - `current_level` saturates by construction because of the `max_level` check.
  - `w_addr` is computed in 32 bits; `part_idx` bits shifted above bit 31 are discarded.

## Timing
- All outputs are registered.
- Reset values:
  - `word_in=0`, `word_in_valid=0`, `w_addr=0`, `control=0`, `last_input_in=0`, `current_level=0`.
  - `part_req=0`, `part_idx=0`, `part_phase=0`, `in_ready=0`, `busy=0`, `done=0`, `levels_run=0`.
  - State goes to IDLE.
- Forwarding: a line accepted on cycle t appears on `word_in` with `word_in_valid` at t+1.
- `in_ready` is combinational from state. Upstream may insert bubbles; no `word_in_valid` pulse is produced without a handshake.
- `rst` mid-run aborts immediately to the reset values. No `done` is produced. Upstream must be reset together with this block.
- `pipe_last_out` arriving while in DRAIN's counting phase is ignored.
- An empty edge phase is valid: `in_last` on the first handshake.

## Test plan
- Single partition, `VERTEX_LINES=2`, 3 edge lines, no `pipe_valid_out`:
  - Two `control=1` lines at `w_addr` 0 and 1.
  - Three `control=2` lines, with `last_input_in` on the third.
  - `done` with `levels_run=1`.
- `num_partitions=3`: the second partition's vertex lines go to `w_addr` 0x100 and 0x101 (ADDR_W=8); `part_req` pulses 6 times per level.
- Inject `pipe_valid_out=4'b0010` during level 0 with `max_level=5`, none afterwards: exactly 2 levels run and `current_level` reaches 1.
- Updates every level with `max_level=2`: `levels_run=3`, then `done`.
- `in_valid` toggling every other cycle: `word_in_valid` count equals the handshake count; `control` stays 2 through DRAIN until `DRAIN` cycles after `pipe_last_out`.
- `rst` asserted in STREAM_E: next cycle all outputs are at reset values; a following `start` runs cleanly; `start` with `num_partitions=0` gives `done` with `levels_run=0`.
